// File: rtl/fmrv32im_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, step count,
// divide-by-zero quotient and small datapath helpers.
package fmrv32im_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Decoded operation after priority resolution
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } op_t;

  localparam int          STEP_COUNT    = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // DIV > DIVU > REM > REMU when several selects are high
  function automatic op_t sel_op(input logic div, input logic divu,
                                 input logic rem, input logic remu);
    op_t op;
    op = OP_REMU;
    if (div)       op = OP_DIV;
    else if (divu) op = OP_DIVU;
    else if (rem)  op = OP_REM;
    else if (remu) op = OP_REMU;
    return op;
  endfunction

  // Two's-complement negate when neg is set
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/fmrv32im_div_if.sv
// Request/response bundle between the pipeline and the divider.
interface fmrv32im_div_if;
  logic        VALID;
  logic        INST_DIV;
  logic        INST_DIVU;
  logic        INST_REM;
  logic        INST_REMU;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic        KILL;
  logic        BUSY;
  logic        RD_VALID;
  logic [31:0] RD_RESULT;

  // Pipeline side
  modport master (
    output VALID, INST_DIV, INST_DIVU, INST_REM, INST_REMU, RS1, RS2, KILL,
    input  BUSY, RD_VALID, RD_RESULT
  );

  // Divider side
  modport slave (
    input  VALID, INST_DIV, INST_DIVU, INST_REM, INST_REMU, RS1, RS2, KILL,
    output BUSY, RD_VALID, RD_RESULT
  );
endinterface

// File: rtl/fmrv32im_div.sv
// 32-bit restoring divider for DIV/DIVU/REM/REMU. One quotient bit per
// cycle, sign fix-up in a separate state, divide-by-zero short-circuits
// straight to DONE.
module fmrv32im_div
  import fmrv32im_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  fmrv32im_div_if.slave bus
);

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] quot_reg;      // holds dividend, shifts into quotient
  logic [31:0] divisor_reg;
  logic [32:0] rem_reg;       // partial remainder, one spare bit
  logic        q_sign_reg;
  logic        r_sign_reg;
  logic        is_rem_reg;
  logic        busy_reg;
  logic        rd_valid_reg;
  logic [31:0] rd_result_reg;

  logic        start;
  op_t         op_sel;
  logic        op_signed;
  logic        op_rem;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        step_ok;
  logic [32:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] fix_result;

  assign start = bus.VALID &
                 (bus.INST_DIV | bus.INST_DIVU | bus.INST_REM | bus.INST_REMU);

  // Decode the requested operation and one restoring step
  always_comb begin
    op_sel    = sel_op(bus.INST_DIV, bus.INST_DIVU, bus.INST_REM, bus.INST_REMU);
    op_signed = (op_sel == OP_DIV) || (op_sel == OP_REM);
    op_rem    = (op_sel == OP_REM) || (op_sel == OP_REMU);

    rem_shift = {rem_reg[31:0], quot_reg[31]};
    rem_diff  = rem_shift - {1'b0, divisor_reg};
    step_ok   = ~rem_diff[32];
    rem_next  = step_ok ? rem_diff : rem_shift;
    quot_next = {quot_reg[30:0], step_ok};

    fix_result = is_rem_reg ? cond_neg(rem_reg[31:0], r_sign_reg)
                            : cond_neg(quot_reg, q_sign_reg);
  end

  // Control FSM, operand registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= 6'd0;
      quot_reg      <= 32'd0;
      divisor_reg   <= 32'd0;
      rem_reg       <= 33'd0;
      q_sign_reg    <= 1'b0;
      r_sign_reg    <= 1'b0;
      is_rem_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_result_reg <= 32'd0;
    end else if (bus.KILL) begin
      // Flush wins over everything, including a same-cycle start
      state_reg    <= IDLE;
      cnt_reg      <= 6'd0;
      busy_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          rd_valid_reg <= 1'b0;
          if (start) begin
            is_rem_reg  <= op_rem;
            quot_reg    <= cond_neg(bus.RS1, op_signed & bus.RS1[31]);
            divisor_reg <= cond_neg(bus.RS2, op_signed & bus.RS2[31]);
            q_sign_reg  <= op_signed & (bus.RS1[31] ^ bus.RS2[31]);
            r_sign_reg  <= op_signed & bus.RS1[31];
            rem_reg     <= 33'd0;
            cnt_reg     <= 6'd0;
            busy_reg    <= 1'b1;
            if (bus.RS2 == 32'd0) begin
              // Remainder of x/0 is the raw dividend, independent of sign
              state_reg     <= DONE;
              rd_valid_reg  <= 1'b1;
              rd_result_reg <= op_rem ? bus.RS1 : DIV_ZERO_QUOT;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg  <= rem_next;
          quot_reg <= quot_next;
          if (cnt_reg == 6'(STEP_COUNT - 1)) begin
            cnt_reg   <= 6'd0;
            state_reg <= FIX;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        FIX: begin
          rd_result_reg <= fix_result;
          rd_valid_reg  <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          // Any start seen here is dropped; next accept is from IDLE
          rd_valid_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          rd_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY      = busy_reg;
  assign bus.RD_VALID  = rd_valid_reg;
  assign bus.RD_RESULT = rd_result_reg;

endmodule

// File: tb/tb_fmrv32im_div.sv
// Self-checking bench for fmrv32im_div: directed corner cases, random
// operations against an arithmetic reference, kill, start-in-DONE and
// asynchronous reset scenarios.
module tb_fmrv32im_div;

  logic CLK = 1'b0;
  logic RST;

  fmrv32im_div_if bus ();

  fmrv32im_div dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, obs, exp);
    end
  endtask

  // sel bits: [3]=DIV [2]=DIVU [1]=REM [0]=REMU
  function automatic logic [31:0] ref_model(input logic [3:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    bit is_signed, want_rem;
    int sa, sb;
    if (sel[3])      begin is_signed = 1; want_rem = 0; end
    else if (sel[2]) begin is_signed = 0; want_rem = 0; end
    else if (sel[1]) begin is_signed = 1; want_rem = 1; end
    else             begin is_signed = 0; want_rem = 1; end
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'd0 : a;
      sa = int'(a);
      sb = int'(b);
      return want_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return want_rem ? (a % b) : (a / b);
  endfunction

  task automatic drive_idle();
    bus.VALID     = 1'b0;
    bus.INST_DIV  = 1'b0;
    bus.INST_DIVU = 1'b0;
    bus.INST_REM  = 1'b0;
    bus.INST_REMU = 1'b0;
    bus.RS1       = 32'd0;
    bus.RS2       = 32'd0;
    bus.KILL      = 1'b0;
  endtask

  task automatic drive_start(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    bus.VALID     = 1'b1;
    bus.INST_DIV  = sel[3];
    bus.INST_DIVU = sel[2];
    bus.INST_REM  = sel[1];
    bus.INST_REMU = sel[0];
    bus.RS1       = a;
    bus.RS2       = b;
  endtask

  // Issue one op and check result, latency, BUSY coverage and pulse width
  task automatic run_op(input string name, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
    int n;
    int exp_lat;
    bit busy_ok;
    exp_lat = (b == 32'd0) ? 0 : 33;
    @(negedge CLK);
    drive_start(sel, a, b);
    @(posedge CLK);
    #1 drive_idle();
    n = 0;
    busy_ok = 1;
    @(negedge CLK);
    while (!bus.RD_VALID && n < 60) begin
      if (!bus.BUSY) busy_ok = 0;
      n++;
      @(negedge CLK);
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_result"}, bus.RD_RESULT, exp_res);
    check({name, "_busy_flight"}, 32'(busy_ok), 32'd1);
    check({name, "_busy_done"}, 32'(bus.BUSY), 32'd1);
    @(negedge CLK);
    check({name, "_pulse_end"}, 32'(bus.RD_VALID), 32'd0);
    check({name, "_busy_release"}, 32'(bus.BUSY), 32'd0);
    check({name, "_hold"}, bus.RD_RESULT, exp_res);
    $display("op %s sel=%b a=%08h b=%08h -> %08h lat=%0d", name, sel, a, b, bus.RD_RESULT, n);
  endtask

  // No RD_VALID may appear for the given number of cycles
  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (bus.RD_VALID) seen = 1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [3:0]  sel;
    logic [31:0] a, b;
    int          mode;

    drive_idle();
    RST = 1'b1;
    #1;
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_rd_valid", 32'(bus.RD_VALID), 32'd0);
    check("reset_result", bus.RD_RESULT, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Directed corner cases
    run_op("divu_100_7", 4'b0100, 32'd100, 32'd7, 32'd14);
    run_op("div_neg7_2", 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_neg7_2", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("div_ovf", 4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("divu_by0", 4'b0100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0", 4'b0001, 32'd5, 32'd0, 32'h0000_0005);
    run_op("rem_neg_by0", 4'b0010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
    run_op("prio_all", 4'b1111, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6);
    run_op("prio_rem", 4'b0011, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);

    // Randomized operations against the reference model
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 7));
      sel  = 4'b0001 << $urandom_range(0, 3);
      if (mode == 7) sel = 4'($urandom_range(1, 15));
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 32'd0;
      if (mode == 1) b = 32'($urandom_range(1, 20));
      if (mode == 2) b = -32'($urandom_range(1, 20));
      if (mode == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op($sformatf("rand%0d", t), sel, a, b, ref_model(sel, a, b));
    end

    // Kill at CALC step 10, then restart
    @(negedge CLK);
    drive_start(4'b0100, 32'd1000, 32'd3);
    @(posedge CLK);
    #1 drive_idle();
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    bus.KILL = 1'b1;
    @(posedge CLK);
    #1 bus.KILL = 1'b0;
    @(negedge CLK);
    check("kill_busy", 32'(bus.BUSY), 32'd0);
    expect_quiet("kill_no_valid", 40);
    $display("op kill_mid_calc done");
    run_op("after_kill", 4'b0100, 32'd9, 32'd3, 32'd3);

    // KILL with a start in the same IDLE cycle: start is dropped
    @(negedge CLK);
    drive_start(4'b0100, 32'd50, 32'd5);
    bus.KILL = 1'b1;
    @(posedge CLK);
    #1 drive_idle();
    @(negedge CLK);
    check("kill_prio_busy", 32'(bus.BUSY), 32'd0);
    expect_quiet("kill_prio_no_valid", 40);
    $display("op kill_vs_start done");

    // Start during DONE is ignored
    @(negedge CLK);
    drive_start(4'b0100, 32'd20, 32'd4);
    @(posedge CLK);
    #1 drive_idle();
    for (int i = 0; i < 60 && !bus.RD_VALID; i++) @(negedge CLK);
    check("done_start_result", bus.RD_RESULT, 32'd5);
    drive_start(4'b0100, 32'd77, 32'd7);
    @(posedge CLK);
    #1 drive_idle();
    @(negedge CLK);
    check("done_start_busy", 32'(bus.BUSY), 32'd0);
    expect_quiet("done_start_no_valid", 40);
    $display("op start_in_done done");

    // Asynchronous reset in the middle of CALC
    @(negedge CLK);
    drive_start(4'b0100, 32'd1000, 32'd3);
    @(posedge CLK);
    #1 drive_idle();
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_busy", 32'(bus.BUSY), 32'd0);
    check("arst_rd_valid", 32'(bus.RD_VALID), 32'd0);
    check("arst_result", bus.RD_RESULT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    expect_quiet("arst_no_valid", 40);
    $display("op reset_mid_calc done");
    run_op("after_reset", 4'b0100, 32'd9, 32'd3, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
